int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Memory-mapped interrupt controller sitting directly upstream of the pipelined CPU core; drives the core's INT input.
- Collects up to N_IRQ peripheral request lines, synchronises them and latches pending requests (edge or level mode per line).
- Applies a mask and asserts a registered INT level while any unmasked request is pending.
- The core reads and clears state through the MIO bus, using the same word-address/write-strobe/data path as data memory.

Parameters:
N_IRQ, 8, number of request lines (1..31)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
irq_in  input  N_IRQ  asynchronous peripheral requests, active-high
sel  input  1  bus decode hit for this block (from MIO address decoder)
addr  input  2  register select = core Addr_out[3:2]
we  input  1  write strobe (core mem_w qualified by sel)
wdata  input  32  write data (core Data_out)
rdata  output  32  read data to core Data_in mux, combinational
INT  output  1  interrupt request to core, registered level

Behaviour:
- One clock, clk. reset is synchronous, active-high.
- Reset clears all state:
  - s1, s2, s3 = 0; PENDING = 0; MASK = 0; EDGE = all 1 (edge mode); INT = 0.
  - rdata follows the reset register values.
- Synchroniser, each line i:
  - s1 <= irq_in; s2 <= s1; s3 <= s2.
  - rise[i] = s2[i] & ~s3[i].
- Pending update, every clock:
  - Edge line (EDGE[i]=1): PENDING[i] <= rise[i] | (PENDING[i] & ~clr[i]).
  - Level line (EDGE[i]=0): PENDING[i] <= s2[i]. W1C has no effect on level lines.
  - clr[i] = sel & we & (addr==0) & wdata[i].
  - A set and a clear on the same bit in the same cycle: set wins.
- INT <= |(PENDING & MASK), registered. It therefore reflects PENDING/MASK values from the previous cycle.
- Latency:
  - irq_in rises and is stable before clock edge 1: PENDING set at edge 3, INT high at edge 4.
  - After a clearing write at edge k: INT low at edge k+1, provided no other unmasked bit is pending.
- Register map (addr):
  - 0 PENDING: read = {0, PENDING}. Write = W1C on edge-mode bits.
  - 1 MASK: read/write bits [N_IRQ-1:0]. Upper bits read 0, writes to them ignored.
  - 2 VECTOR: read-only; writes ignored.
    - bit31 = |(PENDING & MASK).
    - bits[4:0] = lowest index i with PENDING[i] & MASK[i] (lowest index = highest priority), else 0.
    - All other bits 0.
  - 3 EDGE: read/write, per-line mode. 1 = edge, 0 = level.
- rdata is combinational from addr and current registers, independent of sel/we, so the core's MEM stage can latch it in the same cycle.
- Reads have no side effects.
- Writes take effect at the clock edge where sel & we is high; new MASK/EDGE values are used from the next cycle.
- Switching a line from level to edge mode: PENDING[i] keeps its current value until cleared.
- Switching a line from edge to level mode: PENDING[i] tracks s2[i] from the next cycle.
- A rising edge on a masked line still sets PENDING. Unmasking later asserts INT one cycle after the MASK write.
- Pulses shorter than one clk period may be missed. Peripherals must hold irq_in for at least 2 cycles.
- Reset asserted mid-operation: all state returns to reset values at that edge. Synchroniser contents are discarded, so a still-high level input re-registers as a new rise 3 edges after reset deasserts.

Test Plan:
- Reset, then MASK=0x01 and irq_in[0] 0→1 held 5 cycles → PENDING=0x01 at edge 3, INT=1 at edge 4, VECTOR=0x8000_0000.
- irq_in[5] and irq_in[2] rise together, MASK=0xFF → VECTOR=0x8000_0002; write PENDING=0x04 → VECTOR=0x8000_0005, INT stays 1; write 0x20 → INT=0 one edge later.
- MASK=0, irq_in[3] pulses → PENDING=0x08, INT=0; write MASK=0x08 → INT=1 one edge after the write.
- W1C of bit 1 in the same cycle as rise[1] → PENDING[1] stays 1, INT stays/becomes 1.
- EDGE=0xFE, irq_in[0] held high; write PENDING=0x01 → PENDING[0] stays 1; irq_in[0] low → PENDING[0]=0 3 edges later, INT=0 one edge after that.
- Reset asserted while INT=1 and PENDING=0x81 → INT=0, PENDING=0, MASK=0, EDGE reads 0xFF after that edge; writes to VECTOR have no effect.

Source files
------------

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: synchronises request lines, latches pending
// state per line in edge or level mode, masks them and drives a registered INT to the core.
module int_ctrl #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             INT
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_VECTOR  = 2'd2;
    localparam logic [1:0] ADDR_EDGE    = 2'd3;

    logic [N_IRQ-1:0] s1_r, s2_r, s3_r;
    logic [N_IRQ-1:0] pending_r, mask_r, edge_r;
    logic             int_r;

    logic [N_IRQ-1:0] rise_s, clr_s, active_s, pending_nxt_s;
    logic             wr_s;
    logic [4:0]       vec_idx_s;
    logic             unused_wdata_s;

    // Lowest set index wins; scanning downward lets lower indices overwrite higher ones.
    function automatic logic [4:0] lowest_index(input logic [N_IRQ-1:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            idx = v[i] ? 5'(i) : idx;
        end
        return idx;
    endfunction

    assign wr_s           = sel & we;
    assign rise_s         = s2_r & ~s3_r;
    assign active_s       = pending_r & mask_r;
    assign vec_idx_s      = lowest_index(active_s);
    assign unused_wdata_s = ^wdata;
    assign INT            = int_r;

    // W1C strobe and next pending value; a rise in the same cycle overrides a clear.
    always_comb begin
        clr_s = '0;
        if (wr_s && (addr == ADDR_PENDING)) begin
            clr_s = wdata[N_IRQ-1:0];
        end else begin
            clr_s = '0;
        end
        pending_nxt_s = (edge_r & (rise_s | (pending_r & ~clr_s))) | (~edge_r & s2_r);
    end

    // Synchroniser, pending/mask/mode registers and the registered interrupt level.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r      <= '0;
            s2_r      <= '0;
            s3_r      <= '0;
            pending_r <= '0;
            mask_r    <= '0;
            edge_r    <= '1;
            int_r     <= 1'b0;
        end else begin
            s1_r      <= irq_in;
            s2_r      <= s1_r;
            s3_r      <= s2_r;
            pending_r <= pending_nxt_s;
            int_r     <= |active_s;
            if (wr_s && (addr == ADDR_MASK)) begin
                mask_r <= wdata[N_IRQ-1:0];
            end else begin
                mask_r <= mask_r;
            end
            if (wr_s && (addr == ADDR_EDGE)) begin
                edge_r <= wdata[N_IRQ-1:0];
            end else begin
                edge_r <= edge_r;
            end
        end
    end

    // Read mux: combinational so the core can capture it in the same cycle.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_PENDING: rdata[N_IRQ-1:0] = pending_r;
            ADDR_MASK:    rdata[N_IRQ-1:0] = mask_r;
            ADDR_VECTOR: begin
                rdata[31]  = |active_s;
                rdata[4:0] = vec_idx_s;
            end
            ADDR_EDGE:    rdata[N_IRQ-1:0] = edge_r;
            default:      rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: latency, priority, masking, W1C, level mode, reset.
`timescale 1ns/100ps
module tb_int_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_in;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_o;

    int n_checks = 0;
    int n_errors = 0;

    int_ctrl #(.N_IRQ(8)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .sel(sel), .addr(addr),
        .we(we), .wdata(wdata), .rdata(rdata), .INT(int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0; wdata = 32'd0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (int_o !== 1'b0) begin n_errors++; $display("FAIL reset_int got %b exp 0", int_o); end
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL reset_pending got %h exp %h", d, 32'h0); end
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL reset_mask got %h exp %h", d, 32'h0); end
        read_reg(2'd3, d);
        n_checks++;
        if (d !== 32'h0000_00FF) begin n_errors++; $display("FAIL reset_edge got %h exp %h", d, 32'hFF); end
        tick();
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL reset_vector got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_edge_latency();
        logic [31:0] d;
        bus_write(2'd1, 32'h0000_0001);
        irq_in = 8'h01;
        tick();
        tick();
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL lat_pend_e2 got %h exp %h", d, 32'h0); end
        tick();
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h1) begin n_errors++; $display("FAIL lat_pend_e3 got %h exp %h", d, 32'h1); end
        n_checks++;
        if (int_o !== 1'b0) begin n_errors++; $display("FAIL lat_int_e3 got %b exp 0", int_o); end
        tick();
        n_checks++;
        if (int_o !== 1'b1) begin n_errors++; $display("FAIL lat_int_e4 got %b exp 1", int_o); end
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h8000_0000) begin n_errors++; $display("FAIL lat_vector got %h exp %h", d, 32'h8000_0000); end
        tick();
        irq_in = 8'h00;
        bus_write(2'd0, 32'h0000_0001);
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL lat_clr_pend got %h exp %h", d, 32'h0); end
        tick();
        n_checks++;
        if (int_o !== 1'b0) begin n_errors++; $display("FAIL lat_clr_int got %b exp 0", int_o); end
        repeat (4) tick();
    endtask

    task automatic test_priority();
        logic [31:0] d;
        bus_write(2'd1, 32'h0000_00FF);
        irq_in = 8'h24;
        repeat (3) tick();
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h8000_0002) begin n_errors++; $display("FAIL prio_vec_2 got %h exp %h", d, 32'h8000_0002); end
        tick();
        bus_write(2'd0, 32'h0000_0004);
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h8000_0005) begin n_errors++; $display("FAIL prio_vec_5 got %h exp %h", d, 32'h8000_0005); end
        tick();
        n_checks++;
        if (int_o !== 1'b1) begin n_errors++; $display("FAIL prio_int_held got %b exp 1", int_o); end
        bus_write(2'd0, 32'h0000_0020);
        n_checks++;
        if (int_o !== 1'b1) begin n_errors++; $display("FAIL prio_int_at_k got %b exp 1", int_o); end
        tick();
        n_checks++;
        if (int_o !== 1'b0) begin n_errors++; $display("FAIL prio_int_k1 got %b exp 0", int_o); end
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL prio_vec_empty got %h exp %h", d, 32'h0); end
        irq_in = 8'h00;
        repeat (4) tick();
    endtask

    task automatic test_masked();
        logic [31:0] d;
        bus_write(2'd1, 32'h0000_0000);
        irq_in = 8'h08;
        tick();
        tick();
        irq_in = 8'h00;
        repeat (4) tick();
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h8) begin n_errors++; $display("FAIL mask_pend got %h exp %h", d, 32'h8); end
        n_checks++;
        if (int_o !== 1'b0) begin n_errors++; $display("FAIL mask_int_off got %b exp 0", int_o); end
        bus_write(2'd1, 32'h0000_0008);
        n_checks++;
        if (int_o !== 1'b0) begin n_errors++; $display("FAIL mask_int_at_k got %b exp 0", int_o); end
        tick();
        n_checks++;
        if (int_o !== 1'b1) begin n_errors++; $display("FAIL mask_int_k1 got %b exp 1", int_o); end
        bus_write(2'd0, 32'h0000_0008);
        tick();
        n_checks++;
        if (int_o !== 1'b0) begin n_errors++; $display("FAIL mask_clr_int got %b exp 0", int_o); end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        bus_write(2'd1, 32'h0000_0002);
        irq_in = 8'h02;
        repeat (3) tick();
        irq_in = 8'h00;
        repeat (3) tick();
        irq_in = 8'h02;
        tick();
        tick();
        bus_write(2'd0, 32'h0000_0002);
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h2) begin n_errors++; $display("FAIL setwin_pend got %h exp %h", d, 32'h2); end
        tick();
        n_checks++;
        if (int_o !== 1'b1) begin n_errors++; $display("FAIL setwin_int got %b exp 1", int_o); end
        irq_in = 8'h00;
        bus_write(2'd0, 32'h0000_0002);
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL setwin_clr got %h exp %h", d, 32'h0); end
        repeat (4) tick();
    endtask

    task automatic test_level();
        logic [31:0] d;
        bus_write(2'd3, 32'h0000_00FE);
        bus_write(2'd1, 32'h0000_0001);
        irq_in = 8'h01;
        repeat (3) tick();
        tick();
        n_checks++;
        if (int_o !== 1'b1) begin n_errors++; $display("FAIL lvl_int_on got %b exp 1", int_o); end
        bus_write(2'd0, 32'h0000_0001);
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h1) begin n_errors++; $display("FAIL lvl_w1c_ignored got %h exp %h", d, 32'h1); end
        irq_in = 8'h00;
        tick();
        tick();
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h1) begin n_errors++; $display("FAIL lvl_pend_e2 got %h exp %h", d, 32'h1); end
        tick();
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL lvl_pend_e3 got %h exp %h", d, 32'h0); end
        n_checks++;
        if (int_o !== 1'b1) begin n_errors++; $display("FAIL lvl_int_e3 got %b exp 1", int_o); end
        tick();
        n_checks++;
        if (int_o !== 1'b0) begin n_errors++; $display("FAIL lvl_int_e4 got %b exp 0", int_o); end
        bus_write(2'd3, 32'h0000_00FF);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(2'd1, 32'h0000_0081);
        irq_in = 8'h81;
        repeat (4) tick();
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h81) begin n_errors++; $display("FAIL rst_pre_pend got %h exp %h", d, 32'h81); end
        n_checks++;
        if (int_o !== 1'b1) begin n_errors++; $display("FAIL rst_pre_int got %b exp 1", int_o); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (int_o !== 1'b0) begin n_errors++; $display("FAIL rst_int got %b exp 0", int_o); end
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL rst_pend got %h exp %h", d, 32'h0); end
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL rst_mask got %h exp %h", d, 32'h0); end
        read_reg(2'd3, d);
        n_checks++;
        if (d !== 32'hFF) begin n_errors++; $display("FAIL rst_edge got %h exp %h", d, 32'hFF); end
        tick();
        tick();
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL rst_rerise_e2 got %h exp %h", d, 32'h0); end
        tick();
        read_reg(2'd0, d);
        n_checks++;
        if (d !== 32'h81) begin n_errors++; $display("FAIL rst_rerise_e3 got %h exp %h", d, 32'h81); end
        bus_write(2'd2, 32'hFFFF_FFFF);
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL vec_ro got %h exp %h", d, 32'h0); end
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL vec_wr_mask got %h exp %h", d, 32'h0); end
        read_reg(2'd3, d);
        n_checks++;
        if (d !== 32'hFF) begin n_errors++; $display("FAIL vec_wr_edge got %h exp %h", d, 32'hFF); end
        bus_write(2'd1, 32'hFFFF_FF01);
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h01) begin n_errors++; $display("FAIL mask_upper got %h exp %h", d, 32'h01); end
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h8000_0000) begin n_errors++; $display("FAIL vec_after_mask got %h exp %h", d, 32'h8000_0000); end
    endtask

    initial begin
        reset = 1'b0; irq_in = 8'h00; sel = 1'b0; addr = 2'd0; we = 1'b0; wdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_edge_latency();
        test_priority();
        test_masked();
        test_set_wins();
        test_level();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
